// File: rtl/pll_phase_scanner_if.sv
// Signal bundle between command/status logic, the PLL phase setter, the data checker and the scanner.
// slave = scanner side, master = command/checker/setter side.
interface pll_phase_scanner_if #(
    parameter int ERR_W = 16
);
    logic             start;
    logic             abort;
    logic             clksrc_sel;
    logic [7:0]       phase_first;
    logic [7:0]       phase_last;
    logic [7:0]       phase_step;
    logic             check_valid;
    logic             check_err;
    logic             pll_update;
    logic [7:0]       pll_phase;
    logic             pll_clksrc;
    logic             busy;
    logic             done;
    logic [7:0]       cur_phase;
    logic [7:0]       best_phase;
    logic [ERR_W-1:0] best_errs;

    modport master (
        output start, abort, clksrc_sel, phase_first, phase_last, phase_step,
        output check_valid, check_err,
        input  pll_update, pll_phase, pll_clksrc, busy, done, cur_phase, best_phase, best_errs
    );

    modport slave (
        input  start, abort, clksrc_sel, phase_first, phase_last, phase_step,
        input  check_valid, check_err,
        output pll_update, pll_phase, pll_clksrc, busy, done, cur_phase, best_phase, best_errs
    );
endinterface

// File: rtl/pll_phase_scanner.sv
// Sweeps the PLL sampling phase, counts checker errors per point and re-applies the best phase (SCAN_CENTER_EN: centre of longest zero-error run).
// Latency: per point 1 update + SETTLE_CYCLES + WINDOW valid samples + 1 eval cycle; final apply adds SETTLE_CYCLES + 1.
// Backpressure: none; start is ignored while busy, abort returns to idle at the next edge.
module pll_phase_scanner #(
    parameter int SETTLE_CYCLES = 200000,
    parameter int WINDOW        = 4096,
    parameter int ERR_W         = 16
) (
    input  logic                clk,
    input  logic                rstn,
    pll_phase_scanner_if.slave  sif
);
    localparam int SCNT_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam int WCNT_W = (WINDOW > 1) ? $clog2(WINDOW) : 1;

    typedef enum logic [2:0] {
        S_IDLE, S_LOAD, S_SETTLE, S_MEASURE, S_EVAL, S_APPLY, S_APPLY_SETTLE, S_FINISH
    } state_t;

    state_t             state_q, state_d;
    logic [SCNT_W-1:0]  cnt_q, cnt_d;
    logic [WCNT_W-1:0]  samp_q, samp_d;
    logic [ERR_W-1:0]   errs_q, errs_d;
    logic [7:0]         cur_phase_q, cur_phase_d;
    logic [7:0]         last_q, last_d;
    logic [7:0]         step_q, step_d;
    logic               clksrc_q, clksrc_d;
    logic [7:0]         run_phase_q, run_phase_d;
    logic [ERR_W-1:0]   run_errs_q, run_errs_d;
    logic [7:0]         best_phase_q, best_phase_d;
    logic [ERR_W-1:0]   best_errs_q, best_errs_d;
    logic [7:0]         pll_phase_q, pll_phase_d;
    logic               pll_clksrc_q, pll_clksrc_d;

    logic               settle_end;
    logic               samp_last;
    logic [8:0]         next_phase;
    logic               sweep_end;
    logic [7:0]         cand_phase;
    logic [ERR_W-1:0]   cand_errs;
    logic [7:0]         final_phase;
    logic [ERR_W-1:0]   final_errs;

`ifdef SCAN_CENTER_EN
    logic               in_run_q, in_run_d;
    logic [7:0]         rs_q, rs_d;
    logic [8:0]         rlen_q, rlen_d;
    logic [7:0]         brs_q, brs_d;
    logic [7:0]         bre_q, bre_d;
    logic [8:0]         blen_q, blen_d;
    logic               c_zero;
    logic [7:0]         c_rs;
    logic [8:0]         c_rlen;
    logic [7:0]         c_brs;
    logic [7:0]         c_bre;
    logic [8:0]         c_blen;
    logic [8:0]         mid_sum;
`endif

    assign settle_end = (cnt_q == SCNT_W'(SETTLE_CYCLES - 1));
    assign samp_last  = (samp_q == WCNT_W'(WINDOW - 1));

    // Evaluation of the point just measured, shared by EVAL's next-state and datapath logic
    always_comb begin
        next_phase = {1'b0, cur_phase_q} + {1'b0, step_q};
        sweep_end  = next_phase[8] || (next_phase > {1'b0, last_q});
        if (errs_q < run_errs_q) begin
            cand_phase = cur_phase_q;
            cand_errs  = errs_q;
        end else begin
            cand_phase = run_phase_q;
            cand_errs  = run_errs_q;
        end
        final_phase = cand_phase;
        final_errs  = cand_errs;
`ifdef SCAN_CENTER_EN
        c_zero  = (errs_q == '0);
        c_rs    = (c_zero && !in_run_q) ? cur_phase_q : rs_q;
        c_rlen  = c_zero ? (in_run_q ? rlen_q + 9'd1 : 9'd1) : 9'd0;
        c_brs   = brs_q;
        c_bre   = bre_q;
        c_blen  = blen_q;
        if (c_zero && (c_rlen > blen_q)) begin
            c_brs  = c_rs;
            c_bre  = cur_phase_q;
            c_blen = c_rlen;
        end
        mid_sum = {1'b0, c_brs} + {1'b0, c_bre};
        if (c_blen != 9'd0) begin
            final_phase = mid_sum[8:1];
            final_errs  = '0;
        end
`endif
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:         if (sif.start) state_d = S_LOAD;
            S_LOAD:         state_d = S_SETTLE;
            S_SETTLE:       if (settle_end) state_d = S_MEASURE;
            S_MEASURE:      if (sif.check_valid && samp_last) state_d = S_EVAL;
            S_EVAL:         state_d = sweep_end ? S_APPLY : S_LOAD;
            S_APPLY:        state_d = S_APPLY_SETTLE;
            S_APPLY_SETTLE: if (settle_end) state_d = S_FINISH;
            S_FINISH:       state_d = S_IDLE;
            default:        state_d = S_IDLE;
        endcase
        if (sif.abort) state_d = S_IDLE;
    end

    always_comb begin
        cnt_d        = '0;
        samp_d       = samp_q;
        errs_d       = errs_q;
        cur_phase_d  = cur_phase_q;
        last_d       = last_q;
        step_d       = step_q;
        clksrc_d     = clksrc_q;
        run_phase_d  = run_phase_q;
        run_errs_d   = run_errs_q;
        best_phase_d = best_phase_q;
        best_errs_d  = best_errs_q;
        pll_phase_d  = pll_phase_q;
        pll_clksrc_d = pll_clksrc_q;
`ifdef SCAN_CENTER_EN
        in_run_d = in_run_q;
        rs_d     = rs_q;
        rlen_d   = rlen_q;
        brs_d    = brs_q;
        bre_d    = bre_q;
        blen_d   = blen_q;
`endif
        if (((state_q == S_SETTLE) || (state_q == S_APPLY_SETTLE)) && !settle_end) begin
            cnt_d = cnt_q + SCNT_W'(1);
        end
        case (state_q)
            S_IDLE: begin
                if (state_d == S_LOAD) begin
                    cur_phase_d  = sif.phase_first;
                    last_d       = sif.phase_last;
                    step_d       = (sif.phase_step == 8'd0) ? 8'd1 : sif.phase_step;
                    clksrc_d     = sif.clksrc_sel;
                    run_phase_d  = sif.phase_first;
                    run_errs_d   = '1;
                    pll_phase_d  = sif.phase_first;
                    pll_clksrc_d = sif.clksrc_sel;
`ifdef SCAN_CENTER_EN
                    in_run_d = 1'b0;
                    rs_d     = 8'd0;
                    rlen_d   = 9'd0;
                    brs_d    = 8'd0;
                    bre_d    = 8'd0;
                    blen_d   = 9'd0;
`endif
                end
            end
            S_LOAD: begin
                samp_d = '0;
                errs_d = '0;
            end
            S_MEASURE: begin
                if (sif.check_valid) begin
                    samp_d = samp_q + WCNT_W'(1);
                    if (sif.check_err && (errs_q != '1)) errs_d = errs_q + ERR_W'(1);
                end
            end
            S_EVAL: begin
                run_phase_d = cand_phase;
                run_errs_d  = cand_errs;
`ifdef SCAN_CENTER_EN
                in_run_d = c_zero;
                rs_d     = c_rs;
                rlen_d   = c_rlen;
                brs_d    = c_brs;
                bre_d    = c_bre;
                blen_d   = c_blen;
`endif
                if (state_d == S_LOAD) begin
                    cur_phase_d = next_phase[7:0];
                    pll_phase_d = next_phase[7:0];
                end else if (state_d == S_APPLY) begin
                    best_phase_d = final_phase;
                    best_errs_d  = final_errs;
                    pll_phase_d  = final_phase;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q      <= S_IDLE;
            cnt_q        <= '0;
            samp_q       <= '0;
            errs_q       <= '0;
            cur_phase_q  <= 8'd0;
            last_q       <= 8'd0;
            step_q       <= 8'd1;
            clksrc_q     <= 1'b0;
            run_phase_q  <= 8'd0;
            run_errs_q   <= '1;
            best_phase_q <= 8'd0;
            best_errs_q  <= '1;
            pll_phase_q  <= 8'd0;
            pll_clksrc_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            samp_q       <= samp_d;
            errs_q       <= errs_d;
            cur_phase_q  <= cur_phase_d;
            last_q       <= last_d;
            step_q       <= step_d;
            clksrc_q     <= clksrc_d;
            run_phase_q  <= run_phase_d;
            run_errs_q   <= run_errs_d;
            best_phase_q <= best_phase_d;
            best_errs_q  <= best_errs_d;
            pll_phase_q  <= pll_phase_d;
            pll_clksrc_q <= pll_clksrc_d;
        end
    end

`ifdef SCAN_CENTER_EN
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            in_run_q <= 1'b0;
            rs_q     <= 8'd0;
            rlen_q   <= 9'd0;
            brs_q    <= 8'd0;
            bre_q    <= 8'd0;
            blen_q   <= 9'd0;
        end else begin
            in_run_q <= in_run_d;
            rs_q     <= rs_d;
            rlen_q   <= rlen_d;
            brs_q    <= brs_d;
            bre_q    <= bre_d;
            blen_q   <= blen_d;
        end
    end
`endif

    always_comb begin
        sif.pll_update = (state_q == S_LOAD) || (state_q == S_APPLY);
        sif.busy       = (state_q != S_IDLE) && (state_q != S_FINISH);
        sif.done       = (state_q == S_FINISH);
        sif.pll_phase  = pll_phase_q;
        sif.pll_clksrc = pll_clksrc_q;
        sif.cur_phase  = cur_phase_q;
        sif.best_phase = best_phase_q;
        sif.best_errs  = best_errs_q;
    end
endmodule
